regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side sequencer for the 8-bit register file. Collects results from the ALU and the load path through valid/ready handshakes and buffers them in a small FIFO.
- Drives the register file write port (WriteEn, Waddr, DataIn, Zero_in, Done_in) at one write per cycle.
- Exports a per-register pending scoreboard so decode can stall reads of registers with an in-flight write.

Parameters:
W, 8, data path width
D, 4, register address width (2**D registers)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
AluValid  in  1  ALU result valid
AluReady  out  1  ALU result accepted this cycle
AluAddr  in  D  ALU destination register
AluData  in  W  ALU result
AluZero  in  1  ALU zero flag
AluDone  in  1  ALU done flag
MemValid  in  1  load result valid
MemReady  out  1  load result accepted this cycle
MemAddr  in  D  load destination register
MemData  in  W  load data
Hold  in  1  suppress register file writes this cycle
Flush  in  1  synchronous discard of all queued writes
WriteEn  out  1  register file write enable
Waddr  out  D  register file write address
DataIn  out  W  register file write data
Zero_in  out  1  zero flag to register file
Done_in  out  1  done flag to register file
Pending  out  2**D  bit r=1 iff a queued entry targets register r
Count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (Reset=0, async): FIFO empty, Count=0, WriteEn=0, Pending=0, shadow flags ShZero=0 and ShDone=1. ShDone=1 matches the register file's halt-on-reset default.
- Entry format: {addr, data, zero, done, is_alu}.
- Acceptance is combinational from FIFO state and does not count a same-cycle pop:
  - MemReady = !full & !Flush
  - AluReady = !full & !Flush & !MemValid (load path has priority)
- At most one push per cycle. Push occurs on Valid&Ready.
- Drain: WriteEn = !empty & !Hold. Waddr, DataIn and the flags come combinationally from the FIFO head. The head is popped on the same edge as WriteEn=1.
- Flag outputs:
  - ALU entry: Zero_in/Done_in = entry flags. ShZero/ShDone are updated to those flags when the entry pops.
  - Load entry: Zero_in/Done_in = ShZero/ShDone. The register file therefore keeps its current flags across loads.
- Latency: an entry pushed at edge N is eligible for WriteEn in cycle N+1. Writes occur in FIFO order.
- Simultaneous push and pop:
  - Count unchanged.
  - A full FIFO still refuses the push, even when a pop happens that cycle.
- Pending: one saturating-free counter per register, width $clog2(DEPTH+1).
  - Push to r increments; pop of r decrements; push and pop of the same r leaves it unchanged.
  - Pending[r] = (counter r != 0).
- Hold=1: no pop, WriteEn=0. Pushes continue until full.
- Flush=1 (synchronous):
  - Next edge: FIFO empty, Count=0, all counters 0.
  - WriteEn forced 0 in the Flush cycle; no push or pop occurs.
  - ShZero/ShDone are retained.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (Count==DEPTH), empty = (Count==0).

Optional Feature:
WB_BYPASS_EN
- Defined: when FIFO empty, Hold=0 and Flush=0, an accepted entry is written to the register file in the same cycle, combinationally from the input port. The entry is not enqueued, and Pending/Count do not change. Flag and shadow rules are as for a pop.
- Undefined: every entry passes through the FIFO; minimum latency is one cycle.

Test Plan:
- Reset mid-operation: 3 entries queued, Reset low -> immediately Count=0, WriteEn=0, Pending=0. First load after release writes Zero_in=0, Done_in=1.
- Priority: AluValid=MemValid=1 same cycle, Mem r3=0x5A, ALU r4=0x11 -> MemReady=1, AluReady=0. Writes r3=0x5A then r4=0x11 on consecutive cycles.
- Flags shadow: ALU r1=0x00 Zero=1 Done=0, then load r2=0x7F -> second write has Zero_in=1, Done_in=0.
- Full/Hold: Hold=1, push 4 entries -> Count=4, AluReady=MemReady=0, Pending bits set. Release Hold -> 4 writes in order; Count returns to 0 and Pending clears.
- Scoreboard: two queued writes to r5 -> Pending[5] stays 1 until the second pops. Push r5 same cycle as pop r5 -> Pending[5] stays 1.
- Flush: 2 entries queued, Flush=1 with AluValid=1 -> AluReady=0, WriteEn=0. Next cycle Count=0, Pending=0, ShZero/ShDone unchanged.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-side sequencer: buffers ALU/load results in a FIFO and drains one register file write per cycle.
// Optional same-cycle bypass when the FIFO is empty: define WB_BYPASS_EN.
module regfile_writeback #(
    parameter int W     = 8,
    parameter int D     = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH),
    localparam int NREG = 2 ** D
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            AluValid,
    output logic            AluReady,
    input  logic [D-1:0]    AluAddr,
    input  logic [W-1:0]    AluData,
    input  logic            AluZero,
    input  logic            AluDone,
    input  logic            MemValid,
    output logic            MemReady,
    input  logic [D-1:0]    MemAddr,
    input  logic [W-1:0]    MemData,
    input  logic            Hold,
    input  logic            Flush,
    output logic            WriteEn,
    output logic [D-1:0]    Waddr,
    output logic [W-1:0]    DataIn,
    output logic            Zero_in,
    output logic            Done_in,
    output logic [NREG-1:0] Pending,
    output logic [CW-1:0]   Count
);

    logic [D-1:0]  addr_q [DEPTH];
    logic [D-1:0]  addr_d [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [W-1:0]  data_d [DEPTH];
    logic [DEPTH-1:0] zero_q, zero_d, done_q, done_d, alu_q, alu_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic          sh_zero_q, sh_zero_d, sh_done_q, sh_done_d;

    logic          full, empty, push, enq, pop, bypass;
    logic [D-1:0]  in_addr;
    logic [W-1:0]  in_data;
    logic          in_zero, in_done, in_alu;
    logic          wr_zero, wr_done, wr_alu;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        MemReady = !full && !Flush;
        AluReady = !full && !Flush && !MemValid;
        push     = (MemValid && MemReady) || (AluValid && AluReady);

        // Load path wins the single push slot.
        in_addr  = MemValid ? MemAddr : AluAddr;
        in_data  = MemValid ? MemData : AluData;
        in_zero  = MemValid ? 1'b0 : AluZero;
        in_done  = MemValid ? 1'b0 : AluDone;
        in_alu   = !MemValid;

`ifdef WB_BYPASS_EN
        bypass   = push && empty && !Hold && !Flush;
`else
        bypass   = 1'b0;
`endif
        enq      = push && !bypass;
        pop      = !empty && !Hold && !Flush;
        WriteEn  = pop || bypass;

        if (bypass) begin
            Waddr   = in_addr;
            DataIn  = in_data;
            wr_zero = in_zero;
            wr_done = in_done;
            wr_alu  = in_alu;
        end else begin
            Waddr   = addr_q[rptr_q];
            DataIn  = data_q[rptr_q];
            wr_zero = zero_q[rptr_q];
            wr_done = done_q[rptr_q];
            wr_alu  = alu_q[rptr_q];
        end
        // Loads replay the shadow flags so the register file keeps its current flags.
        Zero_in = wr_alu ? wr_zero : sh_zero_q;
        Done_in = wr_alu ? wr_done : sh_done_q;

        sh_zero_d = sh_zero_q;
        sh_done_d = sh_done_q;
        if (WriteEn && wr_alu) begin
            sh_zero_d = wr_zero;
            sh_done_d = wr_done;
        end

        addr_d  = addr_q;
        data_d  = data_q;
        zero_d  = zero_q;
        done_d  = done_q;
        alu_d   = alu_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CW'(enq) - CW'(pop);
        if (enq) begin
            addr_d[wptr_q] = in_addr;
            data_d[wptr_q] = in_data;
            zero_d[wptr_q] = in_zero;
            done_d[wptr_q] = in_done;
            alu_d[wptr_q]  = in_alu;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop)
            rptr_d = rptr_q + 1'b1;

        for (int unsigned r = 0; r < NREG; r++)
            cnt_d[r] = cnt_q[r] + CW'(enq && (in_addr == D'(r)))
                                - CW'(pop && (addr_q[rptr_q] == D'(r)));

        if (Flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            for (int unsigned r = 0; r < NREG; r++)
                cnt_d[r] = '0;
        end

        Count = count_q;
        for (int unsigned r = 0; r < NREG; r++)
            Pending[r] = (cnt_q[r] != '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q    <= '{default: '0};
            data_q    <= '{default: '0};
            zero_q    <= '0;
            done_q    <= '0;
            alu_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            cnt_q     <= '{default: '0};
            sh_zero_q <= 1'b0;
            sh_done_q <= 1'b1;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            alu_q     <= alu_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            sh_zero_q <= sh_zero_d;
            sh_done_q <= sh_done_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (default build, no bypass).
module tb_regfile_writeback;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        AluValid, AluReady, AluZero, AluDone;
    logic [3:0]  AluAddr;
    logic [7:0]  AluData;
    logic        MemValid, MemReady;
    logic [3:0]  MemAddr;
    logic [7:0]  MemData;
    logic        Hold, Flush;
    logic        WriteEn, Zero_in, Done_in;
    logic [3:0]  Waddr;
    logic [7:0]  DataIn;
    logic [15:0] Pending;
    logic [2:0]  Count;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.W(8), .D(4), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
        .AluZero(AluZero), .AluDone(AluDone),
        .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
        .Hold(Hold), .Flush(Flush),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .Zero_in(Zero_in), .Done_in(Done_in),
        .Pending(Pending), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] a, input logic [7:0] d,
                          input logic z, input logic dn);
        chk({tag, "_we"}, WriteEn, 1);
        chk({tag, "_addr"}, Waddr, a);
        chk({tag, "_data"}, DataIn, d);
        chk({tag, "_zero"}, Zero_in, z);
        chk({tag, "_done"}, Done_in, dn);
    endtask

    initial begin
        Reset = 1'b0; Hold = 0; Flush = 0;
        AluValid = 0; AluAddr = 0; AluData = 0; AluZero = 0; AluDone = 0;
        MemValid = 0; MemAddr = 0; MemData = 0;
        #2;
        chk("rst_count", Count, 0);
        chk("rst_we", WriteEn, 0);
        chk("rst_pend", Pending, 0);
        chk("rst_mrdy", MemReady, 1);
        tick();
        Reset = 1'b1;

        // Priority: load accepted first, ALU waits one cycle.
        MemValid = 1; MemAddr = 3; MemData = 8'h5A;
        AluValid = 1; AluAddr = 4; AluData = 8'h11; AluZero = 0; AluDone = 1;
        #1;
        chk("pri_mrdy", MemReady, 1);
        chk("pri_ardy", AluReady, 0);
        chk("pri_we0", WriteEn, 0);
        tick();
        MemValid = 0;
        #1;
        chk("pri_count", Count, 1);
        chk("pri_pend", Pending, 16'h0008);
        chk("pri_ardy2", AluReady, 1);
        chk_wr("pri_w1", 4'd3, 8'h5A, 1'b0, 1'b1);
        tick();
        AluValid = 0;
        chk("pri_pend2", Pending, 16'h0010);
        chk_wr("pri_w2", 4'd4, 8'h11, 1'b0, 1'b1);
        tick();
        chk("pri_empty", Count, 0);
        chk("pri_we_off", WriteEn, 0);

        // Flag shadow carried onto a following load.
        AluValid = 1; AluAddr = 1; AluData = 8'h00; AluZero = 1; AluDone = 0;
        tick();
        AluValid = 0; MemValid = 1; MemAddr = 2; MemData = 8'h7F;
        #1;
        chk_wr("sh_w1", 4'd1, 8'h00, 1'b1, 1'b0);
        tick();
        MemValid = 0;
        chk_wr("sh_w2", 4'd2, 8'h7F, 1'b1, 1'b0);
        tick();

        // Fill under Hold, then drain in order; full refuses a push even while popping.
        Hold = 1;
        AluValid = 1; AluAddr = 6; AluData = 8'hA1; AluZero = 0; AluDone = 1;
        tick();
        AluValid = 0; MemValid = 1; MemAddr = 7; MemData = 8'hB2;
        tick();
        MemValid = 0; AluValid = 1; AluAddr = 8; AluData = 8'hC3; AluZero = 1; AluDone = 1;
        tick();
        AluValid = 0; MemValid = 1; MemAddr = 9; MemData = 8'hD4;
        tick();
        MemValid = 0;
        #1;
        chk("full_count", Count, 4);
        chk("full_mrdy", MemReady, 0);
        chk("full_ardy", AluReady, 0);
        chk("full_we", WriteEn, 0);
        chk("full_pend", Pending, 16'h03C0);
        Hold = 0; AluValid = 1; AluAddr = 10; AluData = 8'hEE; AluZero = 0; AluDone = 0;
        #1;
        chk("full_ardy_pop", AluReady, 0);
        chk_wr("dr_w1", 4'd6, 8'hA1, 1'b0, 1'b1);
        tick();
        AluValid = 0;
        chk("dr_count", Count, 3);
        chk_wr("dr_w2", 4'd7, 8'hB2, 1'b0, 1'b1);
        tick();
        chk_wr("dr_w3", 4'd8, 8'hC3, 1'b1, 1'b1);
        tick();
        chk_wr("dr_w4", 4'd9, 8'hD4, 1'b1, 1'b1);
        chk("dr_pend4", Pending, 16'h0200);
        tick();
        chk("dr_count0", Count, 0);
        chk("dr_pend0", Pending, 0);
        chk("dr_we0", WriteEn, 0);

        // Scoreboard: two writes to r5, then a push of r5 alongside its pop.
        Hold = 1; MemValid = 1; MemAddr = 5; MemData = 8'h01;
        tick();
        MemData = 8'h02;
        tick();
        MemValid = 0; Hold = 0;
        #1;
        chk("sb_pend_a", Pending, 16'h0020);
        chk("sb_count_a", Count, 2);
        chk("sb_data_a", DataIn, 8'h01);
        tick();
        chk("sb_pend_b", Pending, 16'h0020);
        chk("sb_data_b", DataIn, 8'h02);
        MemValid = 1; MemData = 8'h03;
        tick();
        MemValid = 0;
        chk("sb_pend_c", Pending, 16'h0020);
        chk("sb_count_c", Count, 1);
        chk("sb_data_c", DataIn, 8'h03);
        tick();
        chk("sb_pend_d", Pending, 0);

        // Flush: queued ALU entry (Z0/D0) must not reach the shadow (still Z1/D1).
        Hold = 1; AluValid = 1; AluAddr = 11; AluData = 8'hEE; AluZero = 0; AluDone = 0;
        tick();
        AluValid = 0; MemValid = 1; MemAddr = 12; MemData = 8'h33;
        tick();
        MemValid = 0; Hold = 0; Flush = 1; AluValid = 1; AluAddr = 13;
        #1;
        chk("fl_ardy", AluReady, 0);
        chk("fl_mrdy", MemReady, 0);
        chk("fl_we", WriteEn, 0);
        tick();
        Flush = 0; AluValid = 0;
        chk("fl_count", Count, 0);
        chk("fl_pend", Pending, 0);
        chk("fl_we2", WriteEn, 0);
        MemValid = 1; MemAddr = 13; MemData = 8'h44;
        tick();
        MemValid = 0;
        chk_wr("fl_ld", 4'd13, 8'h44, 1'b1, 1'b1);
        tick();

        // Reset mid-operation with 3 queued entries; shadow returns to Z0/D1.
        Hold = 1; MemValid = 1;
        MemAddr = 1; MemData = 8'h0A; tick();
        MemAddr = 2; MemData = 8'h0B; tick();
        MemAddr = 3; MemData = 8'h0C; tick();
        MemValid = 0; Hold = 0;
        #1;
        chk("rm_count3", Count, 3);
        chk("rm_we1", WriteEn, 1);
        Reset = 0;
        #1;
        chk("rm_count", Count, 0);
        chk("rm_we", WriteEn, 0);
        chk("rm_pend", Pending, 0);
        tick();
        Reset = 1; MemValid = 1; MemAddr = 14; MemData = 8'h55;
        tick();
        MemValid = 0;
        chk_wr("rm_ld", 4'd14, 8'h55, 1'b0, 1'b1);
        tick();
        chk("rm_end", Count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
